// File: rtl/mux_seq_ctrl_pkg.sv
// Shared types and default timing for the project-mux sequencing controller.
package mux_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIESCE,
    S_SWITCH,
    S_HOLD,
    S_RUN
  } state_t;

  localparam int DRAIN_DEF    = 2;
  localparam int RST_HOLD_DEF = 8;
  localparam int CNT_W        = 8;

endpackage

// File: rtl/mux_seq_timer.sv
// Loadable down-counter with zero flag; times both QUIESCE and HOLD.
module mux_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_seq_ctrl.sv
// Break-before-make switch sequencer for wrappers sharing one pad bus:
// gate inputs, drop ena, enable new wrapper under reset, then release.
module mux_seq_ctrl
  import mux_seq_ctrl_pkg::*;
#(
  parameter int NPROJ    = 16,
  parameter int SELW     = $clog2(NPROJ),
  parameter int DRAIN    = DRAIN_DEF,
  parameter int RST_HOLD = RST_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_valid,
  output logic             sel_ready,
  input  logic [SELW-1:0]  sel_addr,
  input  logic             sel_off,
  output logic [NPROJ-1:0] ena,
  output logic             proj_rst_n,
  output logic             in_gate,
  output logic [SELW-1:0]  cur_addr,
  output logic             active,
  output logic             err
);

  localparam logic [SELW:0]    NPROJ_X  = (SELW+1)'(NPROJ);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(RST_HOLD - 1);

  state_t            state_q, state_d;
  logic [SELW-1:0]   tgt_q, tgt_d, cur_addr_q, cur_addr_d;
  logic              off_q, off_d;
  logic              err_q, err_d, sel_ready_q, sel_ready_d;
  logic [NPROJ-1:0]  ena_q, ena_d, onehot;
  logic              proj_rst_n_q, proj_rst_n_d, in_gate_q, in_gate_d;
  logic              active_q, active_d;
  logic              t_load, t_dec, t_zero;
  logic [CNT_W-1:0]  t_val;
  logic              addr_bad;

  assign addr_bad = ({1'b0, sel_addr} >= NPROJ_X);

  mux_seq_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    off_d      = off_q;
    cur_addr_d = cur_addr_q;
    err_d      = 1'b0;
    t_load     = 1'b0;
    t_val      = '0;
    t_dec      = 1'b0;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (sel_valid && sel_ready_q) begin
          if (!sel_off && addr_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = S_QUIESCE;
            tgt_d   = sel_addr;
            off_d   = sel_off;
            t_load  = 1'b1;
            t_val   = DRAIN_LD;
          end
        end
      end
      S_QUIESCE: begin
        if (t_zero) state_d = S_SWITCH;
        else        t_dec   = 1'b1;
      end
      S_SWITCH: begin
        if (off_q) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_HOLD;
          cur_addr_d = tgt_q;
          t_load     = 1'b1;
          t_val      = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (t_zero) state_d = S_RUN;
        else        t_dec   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    sel_ready_d = (state_d == S_IDLE) || (state_d == S_RUN);
  end

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NPROJ; i++)
      if (cur_addr_q == SELW'(i)) onehot[i] = 1'b1;
  end

  // Pad-facing outputs follow state_q one edge later, so ena only
  // ever moves through an all-zero cycle (SWITCH) between projects.
  always_comb begin
    ena_d        = '0;
    proj_rst_n_d = 1'b0;
    in_gate_d    = 1'b1;
    active_d     = 1'b0;
    case (state_q)
      S_QUIESCE: ena_d = ena_q;
      S_HOLD:    ena_d = onehot;
      S_RUN: begin
        ena_d        = onehot;
        proj_rst_n_d = 1'b1;
        in_gate_d    = 1'b0;
        active_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q        <= '0;
      off_q        <= 1'b0;
      cur_addr_q   <= '0;
      err_q        <= 1'b0;
      sel_ready_q  <= 1'b1;
      ena_q        <= '0;
      proj_rst_n_q <= 1'b0;
      in_gate_q    <= 1'b1;
      active_q     <= 1'b0;
    end else begin
      tgt_q        <= tgt_d;
      off_q        <= off_d;
      cur_addr_q   <= cur_addr_d;
      err_q        <= err_d;
      sel_ready_q  <= sel_ready_d;
      ena_q        <= ena_d;
      proj_rst_n_q <= proj_rst_n_d;
      in_gate_q    <= in_gate_d;
      active_q     <= active_d;
    end
  end

  assign sel_ready  = sel_ready_q;
  assign ena        = ena_q;
  assign proj_rst_n = proj_rst_n_q;
  assign in_gate    = in_gate_q;
  assign cur_addr   = cur_addr_q;
  assign active     = active_q;
  assign err        = err_q;

endmodule
